// File: rtl/ps2_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : ps2_pkg                                                    |
// | Description : Shared definitions for the PS/2 keyboard receiver:         |
// |               frame geometry, receive FSM state encoding and the odd     |
// |               parity helper.                                             |
// | Ports       : none (package)                                             |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
package ps2_pkg;

  // A frame is start + data + parity + stop.
  localparam int c_frame_bits = 11;
  localparam int c_data_bits  = c_frame_bits - 3;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2,
    ST_STOP   = 2'd3
  } rx_state_t;

  // True when data plus parity bit carry an odd number of ones.
  function automatic logic odd_parity_ok(input logic [c_data_bits-1:0] data,
                                         input logic                   par);
    return ^{data, par};
  endfunction

endpackage
`default_nettype wire

// File: rtl/ps2_kb_rx_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : ps2_kb_rx_if                                               |
// | Description : Host-side bus of the PS/2 keyboard receiver.               |
// |   KB_read_en    host->rx  pop FIFO head                                  |
// |   KB_clear      host->rx  flush FIFO, clear sticky flags                 |
// |   KB_status     rx->host  FIFO non-empty                                 |
// |   KB_data       rx->host  FIFO head (fall-through)                       |
// |   KB_count      rx->host  occupancy                                      |
// |   KB_overflow / KB_parity_err / KB_frame_err  rx->host sticky flags      |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
interface ps2_kb_rx_if #(
  parameter int FIFO_DEPTH = 16
) ();
  import ps2_pkg::*;

  localparam int c_count_w = $clog2(FIFO_DEPTH) + 1;

  logic                   KB_read_en;
  logic                   KB_clear;
  logic                   KB_status;
  logic [c_data_bits-1:0] KB_data;
  logic [c_count_w-1:0]   KB_count;
  logic                   KB_overflow;
  logic                   KB_parity_err;
  logic                   KB_frame_err;

  modport master (
    output KB_read_en, KB_clear,
    input  KB_status, KB_data, KB_count, KB_overflow, KB_parity_err, KB_frame_err
  );

  modport slave (
    input  KB_read_en, KB_clear,
    output KB_status, KB_data, KB_count, KB_overflow, KB_parity_err, KB_frame_err
  );

endinterface
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : sync_fifo                                                  |
// | Description : Single-clock first-word-fall-through FIFO.                 |
// |   clk, rst_n   clock, async active-low reset                             |
// |   clear        flush (wins over push/pop)                                |
// |   push, din    write request / data (write-through when full and popping)|
// |   pop          read request, ignored when empty                          |
// |   dout         head word, 0 when empty                                   |
// |   empty, full, count  status                                             |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  wire                     clk,
  input  wire                     rst_n,
  input  wire                     clear,
  input  wire                     push,
  input  wire                     pop,
  input  wire  [WIDTH-1:0]        din,
  output logic [WIDTH-1:0]        dout,
  output logic                    empty,
  output logic                    full,
  output logic [$clog2(DEPTH):0]  count
);

  localparam int c_aw    = $clog2(DEPTH);
  localparam int c_cnt_w = c_aw + 1;

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_depth_chk
    $error("sync_fifo: DEPTH must be a power of two and at least 2");
  end

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [c_aw-1:0]  r_wr_ptr;
  logic [c_aw-1:0]  r_rd_ptr;
  logic [c_aw:0]    r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign empty     = (r_count == '0);
  assign full      = (r_count == c_cnt_w'(DEPTH));
  assign count     = r_count;
  assign w_do_pop  = pop & ~empty;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign w_do_push = push & (~full | w_do_pop);
  assign dout      = empty ? '0 : r_mem[r_rd_ptr];

  always_ff @(posedge clk) begin
    if (w_do_push && !clear) r_mem[r_wr_ptr] <= din;
  end

  // Pointers are exactly c_aw bits wide, so they wrap modulo DEPTH.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (clear) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/ps2_kb_rx.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : ps2_kb_rx                                                  |
// | Description : PS/2 keyboard receiver. Synchronises and glitch-filters    |
// |               the PS/2 lines, deframes 11-bit frames on falling clock    |
// |               edges and buffers accepted scan bytes in a FIFO.           |
// |   mclk     system clock                                                  |
// |   reset    async active-low reset                                        |
// |   ps2_in   raw PS/2 data line                                            |
// |   ps2_clk  raw PS/2 clock line                                           |
// |   kb       host bus (ps2_kb_rx_if.slave)                                 |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module ps2_kb_rx
  import ps2_pkg::*;
#(
  parameter int FIFO_DEPTH     = 16,
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 80000,
  parameter int PARITY_EN      = 1
) (
  input  wire          mclk,
  input  wire          reset,
  input  wire          ps2_in,
  input  wire          ps2_clk,
  ps2_kb_rx_if.slave   kb
);

  localparam int c_flt_w = $clog2(FILTER_LEN + 1);
  localparam int c_to_w  = $clog2(TIMEOUT_CYCLES + 1);
  localparam int c_bit_w = $clog2(c_data_bits);
  localparam logic [c_flt_w-1:0] c_flt_max = c_flt_w'(FILTER_LEN - 1);
  localparam logic [c_to_w-1:0]  c_to_max  = c_to_w'(TIMEOUT_CYCLES - 1);
  localparam logic [c_bit_w-1:0] c_bit_max = c_bit_w'(c_data_bits - 1);

  logic r_clk_meta, r_clk_sync, r_dat_meta, r_dat_sync;
  logic r_filt_clk;
  logic [c_flt_w-1:0] r_filt_cnt;
  logic w_strobe;

  rx_state_t r_state, w_state_nxt;
  logic [c_bit_w-1:0]     r_bit_cnt, w_bit_cnt_nxt;
  logic [c_data_bits-1:0] r_shift, w_shift_nxt;
  logic                   r_par, w_par_nxt;
  logic [c_to_w-1:0]      r_to_cnt;
  logic w_timeout, w_push, w_perr_set, w_ferr_set;

  logic w_empty, w_full;
  logic [$clog2(FIFO_DEPTH):0] w_count;
  logic r_ovf, r_perr, r_ferr;

  always_ff @(posedge mclk or negedge reset) begin
    if (!reset) begin
      r_clk_meta <= 1'b1;
      r_clk_sync <= 1'b1;
      r_dat_meta <= 1'b1;
      r_dat_sync <= 1'b1;
    end else begin
      r_clk_meta <= ps2_clk;
      r_clk_sync <= r_clk_meta;
      r_dat_meta <= ps2_in;
      r_dat_sync <= r_dat_meta;
    end
  end

  // Filtered clock flips only after FILTER_LEN consecutive differing samples.
  always_ff @(posedge mclk or negedge reset) begin
    if (!reset) begin
      r_filt_clk <= 1'b1;
      r_filt_cnt <= '0;
    end else if (r_clk_sync == r_filt_clk) begin
      r_filt_cnt <= '0;
    end else if (r_filt_cnt == c_flt_max) begin
      r_filt_clk <= r_clk_sync;
      r_filt_cnt <= '0;
    end else begin
      r_filt_cnt <= r_filt_cnt + 1'b1;
    end
  end

  // Strobe is the cycle in which the filtered clock is about to fall.
  assign w_strobe  = r_filt_clk & ~r_clk_sync & (r_filt_cnt == c_flt_max);
  assign w_timeout = (r_state != ST_IDLE) & ~w_strobe & (r_to_cnt == c_to_max);

  always_ff @(posedge mclk or negedge reset) begin
    if (!reset) begin
      r_state   <= ST_IDLE;
      r_bit_cnt <= '0;
      r_shift   <= '0;
      r_par     <= 1'b0;
      r_to_cnt  <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_bit_cnt <= w_bit_cnt_nxt;
      r_shift   <= w_shift_nxt;
      r_par     <= w_par_nxt;
      if (r_state == ST_IDLE || w_strobe || w_timeout) r_to_cnt <= '0;
      else                                            r_to_cnt <= r_to_cnt + 1'b1;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_bit_cnt_nxt = r_bit_cnt;
    w_shift_nxt   = r_shift;
    w_par_nxt     = r_par;
    w_push        = 1'b0;
    w_perr_set    = 1'b0;
    w_ferr_set    = 1'b0;
    if (w_strobe) begin
      case (r_state)
        ST_IDLE: begin
          if (!r_dat_sync) begin
            w_state_nxt   = ST_DATA;
            w_bit_cnt_nxt = '0;
          end else begin
            w_ferr_set = 1'b1;
          end
        end
        ST_DATA: begin
          w_shift_nxt   = {r_dat_sync, r_shift[c_data_bits-1:1]};
          w_bit_cnt_nxt = r_bit_cnt + 1'b1;
          if (r_bit_cnt == c_bit_max) w_state_nxt = ST_PARITY;
        end
        ST_PARITY: begin
          w_par_nxt   = r_dat_sync;
          w_state_nxt = ST_STOP;
        end
        default: begin
          w_state_nxt = ST_IDLE;
          if (!r_dat_sync)
            w_ferr_set = 1'b1;
          else if ((PARITY_EN != 0) && !odd_parity_ok(r_shift, r_par))
            w_perr_set = 1'b1;
          else
            w_push = 1'b1;
        end
      endcase
    end else if (w_timeout) begin
      w_state_nxt = ST_IDLE;
      w_ferr_set  = 1'b1;
    end
  end

  sync_fifo #(
    .WIDTH (c_data_bits),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (mclk),
    .rst_n (reset),
    .clear (kb.KB_clear),
    .push  (w_push),
    .pop   (kb.KB_read_en),
    .din   (r_shift),
    .dout  (kb.KB_data),
    .empty (w_empty),
    .full  (w_full),
    .count (w_count)
  );

  // Clear has priority over any flag set in the same cycle.
  always_ff @(posedge mclk or negedge reset) begin
    if (!reset) begin
      r_ovf  <= 1'b0;
      r_perr <= 1'b0;
      r_ferr <= 1'b0;
    end else if (kb.KB_clear) begin
      r_ovf  <= 1'b0;
      r_perr <= 1'b0;
      r_ferr <= 1'b0;
    end else begin
      if (w_push && w_full && !(kb.KB_read_en && !w_empty)) r_ovf <= 1'b1;
      if (w_perr_set) r_perr <= 1'b1;
      if (w_ferr_set) r_ferr <= 1'b1;
    end
  end

  assign kb.KB_status     = ~w_empty;
  assign kb.KB_count      = w_count;
  assign kb.KB_overflow   = r_ovf;
  assign kb.KB_parity_err = r_perr;
  assign kb.KB_frame_err  = r_ferr;

endmodule
`default_nettype wire

// File: tb/tb_ps2_kb_rx.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_ps2_kb_rx                                               |
// | Description : Scoreboard bench for ps2_kb_rx. Frames are generated with  |
// |               a PS/2 line driver; expected bytes and flags come from a   |
// |               frame-level model; a monitor checks every popped byte.     |
// | Ports       : none                                                       |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_ps2_kb_rx;
  import ps2_pkg::*;

  localparam int FD = 16;
  localparam int FL = 8;
  localparam int TO = 400;
  localparam int H  = 20;   // PS/2 half period in mclk cycles

  logic mclk = 1'b0;
  logic reset = 1'b0;
  logic ps2_in = 1'b1;
  logic ps2_clk = 1'b1;

  ps2_kb_rx_if #(.FIFO_DEPTH(FD)) kb ();
  ps2_kb_rx_if #(.FIFO_DEPTH(FD)) kb_np ();

  ps2_kb_rx #(.FIFO_DEPTH(FD), .FILTER_LEN(FL), .TIMEOUT_CYCLES(TO), .PARITY_EN(1)) dut (
    .mclk(mclk), .reset(reset), .ps2_in(ps2_in), .ps2_clk(ps2_clk), .kb(kb));

  ps2_kb_rx #(.FIFO_DEPTH(FD), .FILTER_LEN(FL), .TIMEOUT_CYCLES(TO), .PARITY_EN(0)) dut_np (
    .mclk(mclk), .reset(reset), .ps2_in(ps2_in), .ps2_clk(ps2_clk), .kb(kb_np));

  always #5 mclk = ~mclk;

  int vectors = 0;
  int miscompares = 0;
  logic [7:0] sb_q[$];
  logic exp_ovf = 1'b0, exp_perr = 1'b0, exp_ferr = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every accepted pop must return the oldest expected byte.
  always @(negedge mclk) begin
    if (reset && kb.KB_read_en && !kb.KB_clear && kb.KB_status) begin
      if (sb_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL pop_data: got 0x%0h expected nothing (model empty)", kb.KB_data);
      end else begin
        chk("pop_data", kb.KB_data, sb_q.pop_front());
      end
    end
  end

  // Frame-level reference: accept rules applied to the whole frame.
  function automatic void model_frame(input logic [7:0] d, input logic p, input logic stop);
    if (!stop)                         exp_ferr = 1'b1;
    else if ($countones({d, p}) % 2 == 0) exp_perr = 1'b1;
    else if (sb_q.size() < FD)         sb_q.push_back(d);
    else                               exp_ovf = 1'b1;
  endfunction

  task automatic check_state(input string tag);
    chk({tag, "_status"}, kb.KB_status, 32'(sb_q.size() != 0));
    chk({tag, "_count"}, kb.KB_count, 32'(sb_q.size()));
    chk({tag, "_overflow"}, kb.KB_overflow, exp_ovf);
    chk({tag, "_parity_err"}, kb.KB_parity_err, exp_perr);
    chk({tag, "_frame_err"}, kb.KB_frame_err, exp_ferr);
    if (sb_q.size() != 0) chk({tag, "_head"}, kb.KB_data, sb_q[0]);
  endtask

  task automatic ps2_bit(input logic b);
    repeat (H/2) @(posedge mclk); #1 ps2_in = b;
    repeat (H/2) @(posedge mclk); #1 ps2_clk = 1'b0;
    repeat (H)   @(posedge mclk); #1 ps2_clk = 1'b1;
  endtask

  // The stop-bit fall is timed so that an optional pop lands on the push cycle.
  task automatic send_frame(input logic [7:0] d, input logic bad_par,
                            input logic bad_stop, input logic pop_at_push);
    logic p;
    logic stop;
    p    = ~(^d) ^ bad_par;
    stop = ~bad_stop;
    ps2_bit(1'b0);
    for (int i = 0; i < c_data_bits; i++) ps2_bit(d[i]);
    ps2_bit(p);
    repeat (H/2) @(posedge mclk); #1 ps2_in = stop;
    repeat (H/2) @(posedge mclk); #1 ps2_clk = 1'b0;
    repeat (FL+1) @(posedge mclk); #1 kb.KB_read_en = pop_at_push;
    @(posedge mclk); #1 kb.KB_read_en = 1'b0;
    model_frame(d, p, stop);
    repeat (H-FL-2) @(posedge mclk); #1 ps2_clk = 1'b1;
    repeat (H/2) @(posedge mclk); #1 ps2_in = 1'b1;
    repeat (H) @(posedge mclk); #1;
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge mclk); #1 kb.KB_read_en = 1'b1;
      @(posedge mclk); #1 kb.KB_read_en = 1'b0;
    end
  endtask

  task automatic clear_fifo();
    @(posedge mclk); #1 kb.KB_clear = 1'b1;
    @(posedge mclk); #1 kb.KB_clear = 1'b0;
    sb_q.delete();
    exp_ovf = 1'b0; exp_perr = 1'b0; exp_ferr = 1'b0;
  endtask

  initial begin
    #900_000;
    $display("FAIL watchdog: time limit reached before end of test");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] b;
    kb.KB_read_en = 1'b0; kb.KB_clear = 1'b0;
    kb_np.KB_read_en = 1'b0; kb_np.KB_clear = 1'b0;

    repeat (4) @(posedge mclk); #1;
    check_state("reset");
    chk("reset_data", kb.KB_data, 8'h00);
    reset = 1'b1;
    repeat (4) @(posedge mclk); #1;

    // Single good frame
    send_frame(8'h33, 1'b0, 1'b0, 1'b0);
    check_state("good_33");
    drain(sb_q.size());

    // Bad parity: rejected when enforced, accepted when ignored
    @(posedge mclk); #1 kb_np.KB_clear = 1'b1;
    @(posedge mclk); #1 kb_np.KB_clear = 1'b0;
    send_frame(8'h33, 1'b1, 1'b0, 1'b0);
    check_state("badpar");
    chk("np_status", kb_np.KB_status, 1'b1);
    chk("np_data", kb_np.KB_data, 8'h33);
    chk("np_parity_err", kb_np.KB_parity_err, 1'b0);
    clear_fifo();

    // Read while empty is ignored
    drain(3);
    check_state("underflow");

    // Start bit of 1 is a framing error
    ps2_bit(1'b1);
    repeat (H) @(posedge mclk); #1;
    exp_ferr = 1'b1;
    check_state("badstart");
    clear_fifo();

    // Fill past capacity without reads
    for (int i = 1; i <= FD + 1; i++) send_frame(8'(i), 1'b0, 1'b0, 1'b0);
    check_state("fill17");
    drain(FD);
    check_state("drained");
    clear_fifo();

    // Full FIFO with a pop on the push cycle
    for (int i = 0; i < FD; i++) send_frame(8'($urandom_range(0, 255)), 1'b0, 1'b0, 1'b0);
    send_frame(8'hA7, 1'b0, 1'b0, 1'b1);
    check_state("full_pushpop");
    drain(sb_q.size());
    clear_fifo();

    // Partial frame then silence
    ps2_bit(1'b0);
    for (int i = 0; i < 3; i++) ps2_bit(1'($urandom_range(0, 1)));
    repeat (TO + 1) @(posedge mclk); #1;
    exp_ferr = 1'b1;
    check_state("timeout");
    send_frame(8'h1C, 1'b0, 1'b0, 1'b0);
    check_state("after_timeout");
    drain(sb_q.size());
    clear_fifo();

    // Reset in the middle of a frame
    ps2_bit(1'b0);
    for (int i = 0; i < 4; i++) ps2_bit(1'($urandom_range(0, 1)));
    ps2_in = 1'b1;
    @(posedge mclk); #1 reset = 1'b0;
    sb_q.delete(); exp_ovf = 1'b0; exp_perr = 1'b0; exp_ferr = 1'b0;
    repeat (3) @(posedge mclk); #1 reset = 1'b1;
    repeat (4) @(posedge mclk); #1;
    send_frame(8'h5A, 1'b0, 1'b0, 1'b0);
    check_state("post_reset");
    chk("post_reset_data", kb.KB_data, 8'h5A);
    clear_fifo();
    check_state("after_clear");

    // Randomised traffic
    for (int n = 0; n < 40; n++) begin
      b = 8'($urandom_range(0, 255));
      send_frame(b, 1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 7) == 0),
                 1'($urandom_range(0, 5) == 0));
      check_state("rand");
      if ($urandom_range(0, 2) == 0) drain($urandom_range(0, sb_q.size()));
      if ($urandom_range(0, 15) == 0) clear_fifo();
    end
    drain(sb_q.size());
    check_state("final");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
